// File: rtl/lif_pkg.sv
// Shared definitions for the time-multiplexed LIF neuron block.
// Holds the datapath width, the Q8 fixed-point shift, the adaptation bounds
// for threshold and beta, and the scheduler FSM state encoding.
package lif_pkg;

  localparam int STATE_W  = 8;
  localparam int Q8_SHIFT = 8;

  localparam logic [STATE_W-1:0] THR_MAX  = 8'd220;
  localparam logic [STATE_W-1:0] THR_MIN  = 8'd8;
  localparam logic [STATE_W-1:0] BETA_MAX = 8'd220;
  localparam logic [STATE_W-1:0] BETA_MIN = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

endpackage

// File: rtl/lif_update_core.sv
// Combinational single-neuron LIF update, shared by all neurons.
// Ports:
//   s, th, b, c            : membrane state, threshold, beta (Q8), input current
//   learn_thr, learn_beta  : enable threshold / beta adaptation
//   next_s, next_th, next_b: updated state, threshold, beta
//   spike                  : spike decision taken on the pre-update state
module lif_update_core
  import lif_pkg::*;
#(
  parameter int ADAPT_INC = 295,
  parameter int ADAPT_DEC = 244
) (
  input  logic [STATE_W-1:0] s,
  input  logic [STATE_W-1:0] th,
  input  logic [STATE_W-1:0] b,
  input  logic [STATE_W-1:0] c,
  input  logic               learn_thr,
  input  logic               learn_beta,
  output logic [STATE_W-1:0] next_s,
  output logic [STATE_W-1:0] next_th,
  output logic [STATE_W-1:0] next_b,
  output logic               spike
);

  localparam int PROD_W = 2 * STATE_W + 1;
  localparam logic [PROD_W-1:0] K_INC = PROD_W'(ADAPT_INC);
  localparam logic [PROD_W-1:0] K_DEC = PROD_W'(ADAPT_DEC);

  // Q8 multiply: 17-bit product, shifted down and truncated to the state width.
  function automatic logic [STATE_W-1:0] q8_scale(input logic [STATE_W-1:0] x,
                                                  input logic [PROD_W-1:0]  k);
    logic [PROD_W-1:0] p;
    p = {{(PROD_W-STATE_W){1'b0}}, x} * k;
    return p[Q8_SHIFT +: STATE_W];
  endfunction

  // Unsigned add that clamps at full scale instead of wrapping.
  function automatic logic [STATE_W-1:0] sat_add(input logic [STATE_W-1:0] x,
                                                 input logic [STATE_W-1:0] y);
    logic [STATE_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return sum[STATE_W] ? {STATE_W{1'b1}} : sum[STATE_W-1:0];
  endfunction

  always_comb begin
    spike   = (s >= th);
    next_s  = s;
    next_th = th;
    next_b  = b;
    if (spike) begin
      next_s = '0;
      if (learn_thr && (th < THR_MAX))  next_th = q8_scale(th, K_INC);
      if (learn_beta && (b < BETA_MAX)) next_b  = q8_scale(b, K_INC);
    end else begin
      next_s = sat_add(c, q8_scale(s, {{(PROD_W-STATE_W){1'b0}}, b}));
      if (learn_thr && (th > THR_MIN))  next_th = q8_scale(th, K_DEC);
      if (learn_beta && (b > BETA_MIN)) next_b  = q8_scale(b, K_DEC);
    end
  end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed LIF scheduler: one shared update core walks neurons
// 0..N_NEURONS-1 per timestep, one input current beat per neuron.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   step_start            : begin a timestep (only honoured when idle)
//   learn_thr, learn_beta : adaptation enables, sampled on each accepted beat
//   cur_data/valid/ready  : input current stream for neuron cur_idx
//   cur_idx               : neuron the next beat belongs to
//   spike_vec             : per-neuron spike result, updated as neurons are processed
//   step_done             : one-cycle pulse after the last neuron
//   busy                  : timestep in progress (RUN or DONE)
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS      = 8,
  parameter int INIT_THRESHOLD = 100,
  parameter int INIT_BETA      = 224,
  parameter int ADAPT_INC      = 295,
  parameter int ADAPT_DEC      = 244,
  localparam int IDX_W         = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_start,
  input  logic                 learn_thr,
  input  logic                 learn_beta,
  input  logic [STATE_W-1:0]   cur_data,
  input  logic                 cur_valid,
  output logic                 cur_ready,
  output logic [IDX_W-1:0]     cur_idx,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 step_done,
  output logic                 busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  fsm_t               fsm_q, fsm_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STATE_W-1:0] state_q [N_NEURONS];
  logic [STATE_W-1:0] thr_q   [N_NEURONS];
  logic [STATE_W-1:0] beta_q  [N_NEURONS];
  logic [N_NEURONS-1:0] spike_q;

  logic               accept;
  logic [STATE_W-1:0] next_s, next_th, next_b;
  logic               spike;

  assign cur_ready = (fsm_q == ST_RUN);
  assign accept    = cur_valid & cur_ready;
  assign cur_idx   = idx_q;
  assign spike_vec = spike_q;
  assign step_done = (fsm_q == ST_DONE);
  assign busy      = (fsm_q != ST_IDLE);

  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    case (fsm_q)
      ST_IDLE: begin
        if (step_start) begin
          fsm_d = ST_RUN;
          idx_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            fsm_d = ST_DONE;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= ST_IDLE;
      idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
    end
  end

  lif_update_core #(
    .ADAPT_INC (ADAPT_INC),
    .ADAPT_DEC (ADAPT_DEC)
  ) u_core (
    .s          (state_q[idx_q]),
    .th         (thr_q[idx_q]),
    .b          (beta_q[idx_q]),
    .c          (cur_data),
    .learn_thr  (learn_thr),
    .learn_beta (learn_beta),
    .next_s     (next_s),
    .next_th    (next_th),
    .next_b     (next_b),
    .spike      (spike)
  );

  // Neuron storage: only the neuron addressed by cur_idx is written, on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        thr_q[i]   <= STATE_W'(INIT_THRESHOLD);
        beta_q[i]  <= STATE_W'(INIT_BETA);
      end
      spike_q <= '0;
    end else if (accept) begin
      state_q[idx_q] <= next_s;
      thr_q[idx_q]   <= next_th;
      beta_q[idx_q]  <= next_b;
      spike_q[idx_q] <= spike;
    end
  end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
module tb_lif_tdm_scheduler;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_start = 1'b0;
  logic       learn_thr = 1'b0;
  logic       learn_beta = 1'b0;
  logic [7:0] cur_data = '0;
  logic       cur_valid = 1'b0;

  logic         cur_ready_a, step_done_a, busy_a;
  logic [2:0]   cur_idx_a;
  logic [N-1:0] spike_vec_a;
  logic         cur_ready_b, step_done_b, busy_b;
  logic [2:0]   cur_idx_b;
  logic [N-1:0] spike_vec_b;

  lif_tdm_scheduler #(.N_NEURONS(N)) dut_a (
    .clk(clk), .rst_n(rst_n), .step_start(step_start),
    .learn_thr(learn_thr), .learn_beta(learn_beta),
    .cur_data(cur_data), .cur_valid(cur_valid), .cur_ready(cur_ready_a),
    .cur_idx(cur_idx_a), .spike_vec(spike_vec_a),
    .step_done(step_done_a), .busy(busy_a)
  );

  lif_tdm_scheduler #(.N_NEURONS(N), .INIT_THRESHOLD(250)) dut_b (
    .clk(clk), .rst_n(rst_n), .step_start(step_start),
    .learn_thr(learn_thr), .learn_beta(learn_beta),
    .cur_data(cur_data), .cur_valid(cur_valid), .cur_ready(cur_ready_b),
    .cur_idx(cur_idx_b), .spike_vec(spike_vec_b),
    .step_done(step_done_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    step_start = 1'b0;
    cur_valid  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // One full timestep with continuous valid; lat = edges from start to step_done.
  task automatic run_step(input logic [7:0] cur, input bit lt, input bit lb,
                          output int lat);
    learn_thr  = lt;
    learn_beta = lb;
    cur_data   = cur;
    cur_valid  = 1'b1;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    lat = 0;
    while (!step_done_a && lat < 200) begin
      tick();
      lat++;
    end
    cur_valid = 1'b0;
    if (!step_done_a) lat = -1;
    tick();
    check("step_done one cycle", int'(step_done_a), 0);
    check("idle after step", int'(busy_a), 0);
  endtask

  typedef struct {
    bit   rst;
    bit   use_b;
    logic [7:0] cur;
    bit   lt;
    bit   lb;
    int   s;
    int   th;
    int   b;
    int   sv;
  } vec_t;

  vec_t vt[16];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt;
    bit seen;

    //          rst use_b cur  lt lb  s    th   b    sv
    vt[0]  = '{1'b1, 1'b0, 8'd50,  1'b0, 1'b0, 50,  100, 224, 0};
    vt[1]  = '{1'b0, 1'b0, 8'd50,  1'b0, 1'b0, 93,  100, 224, 0};
    vt[2]  = '{1'b0, 1'b0, 8'd50,  1'b0, 1'b0, 131, 100, 224, 0};
    vt[3]  = '{1'b0, 1'b0, 8'd50,  1'b0, 1'b0, 0,   100, 224, 255};
    vt[4]  = '{1'b0, 1'b0, 8'd50,  1'b0, 1'b0, 50,  100, 224, 0};
    vt[5]  = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 0,   95,  224, 0};
    vt[6]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 0,   100, 213, 0};
    vt[7]  = '{1'b1, 1'b0, 8'd200, 1'b0, 1'b0, 200, 100, 224, 0};
    vt[8]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 0,   115, 224, 255};
    vt[9]  = '{1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 0,   109, 224, 0};
    vt[10] = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 0,   100, 213, 0};
    vt[11] = '{1'b0, 1'b0, 8'd200, 1'b0, 1'b0, 200, 100, 213, 0};
    vt[12] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 0,   100, 245, 255};
    vt[13] = '{1'b1, 1'b1, 8'd200, 1'b0, 1'b0, 200, 250, 224, 0};
    vt[14] = '{1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 255, 250, 224, 0};
    vt[15] = '{1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 0,   250, 224, 255};

    // Reset state
    do_reset();
    check("rst busy", int'(busy_a), 0);
    check("rst cur_ready", int'(cur_ready_a), 0);
    check("rst cur_idx", int'(cur_idx_a), 0);
    check("rst spike_vec", int'(spike_vec_a), 0);
    check("rst step_done", int'(step_done_a), 0);
    check("rst state0", int'(dut_a.state_q[0]), 0);
    check("rst thr7", int'(dut_a.thr_q[7]), 100);
    check("rst beta7", int'(dut_a.beta_q[7]), 224);

    // Table-driven timesteps
    for (int k = 0; k < 16; k++) begin
      if (vt[k].rst) do_reset();
      run_step(vt[k].cur, vt[k].lt, vt[k].lb, lat);
      check($sformatf("v%0d latency", k), lat, N);
      if (vt[k].use_b) begin
        check($sformatf("v%0d state0", k), int'(dut_b.state_q[0]), vt[k].s);
        check($sformatf("v%0d state7", k), int'(dut_b.state_q[N-1]), vt[k].s);
        check($sformatf("v%0d thr0", k), int'(dut_b.thr_q[0]), vt[k].th);
        check($sformatf("v%0d beta0", k), int'(dut_b.beta_q[0]), vt[k].b);
        check($sformatf("v%0d spike_vec", k), int'(spike_vec_b), vt[k].sv);
      end else begin
        check($sformatf("v%0d state0", k), int'(dut_a.state_q[0]), vt[k].s);
        check($sformatf("v%0d state7", k), int'(dut_a.state_q[N-1]), vt[k].s);
        check($sformatf("v%0d thr0", k), int'(dut_a.thr_q[0]), vt[k].th);
        check($sformatf("v%0d beta0", k), int'(dut_a.beta_q[0]), vt[k].b);
        check($sformatf("v%0d spike_vec", k), int'(spike_vec_a), vt[k].sv);
      end
    end

    // Stall of 5 cycles at cur_idx=3
    do_reset();
    run_step(8'd50, 1'b0, 1'b0, lat);
    learn_thr  = 1'b0;
    learn_beta = 1'b0;
    cur_data   = 8'd50;
    cur_valid  = 1'b1;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    cnt = 0;
    while (cur_idx_a != 3'd3 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("stall reach idx", cnt, 3);
    cur_valid = 1'b0;
    repeat (5) begin
      tick();
      cnt++;
    end
    check("stall idx hold", int'(cur_idx_a), 3);
    check("stall ready", int'(cur_ready_a), 1);
    check("stall state3 hold", int'(dut_a.state_q[3]), 50);
    check("stall state2 done", int'(dut_a.state_q[2]), 93);
    cur_valid = 1'b1;
    while (!step_done_a && cnt < 100) begin
      tick();
      cnt++;
    end
    check("stall latency", cnt, N + 5);
    check("stall state3 final", int'(dut_a.state_q[3]), 93);
    cur_valid = 1'b0;
    tick();

    // step_start during RUN and DONE; cur_valid while IDLE
    do_reset();
    cur_data   = 8'd50;
    cur_valid  = 1'b1;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    tick();
    tick();
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    check("start in RUN ignored idx", int'(cur_idx_a), 3);
    cnt = 3;
    while (!step_done_a && cnt < 100) begin
      tick();
      cnt++;
    end
    check("start in RUN latency", cnt, N);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    check("start in DONE ignored", int'(busy_a), 0);
    cur_data = 8'd99;
    repeat (3) tick();
    check("idle cur_ready", int'(cur_ready_a), 0);
    check("idle no update", int'(dut_a.state_q[0]), 50);
    check("idle cur_idx", int'(cur_idx_a), 0);
    cur_valid = 1'b0;

    // Reset in the middle of a timestep at cur_idx=4
    do_reset();
    run_step(8'd200, 1'b0, 1'b0, lat);
    run_step(8'd0, 1'b0, 1'b0, lat);
    learn_thr  = 1'b1;
    cur_data   = 8'd50;
    cur_valid  = 1'b1;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    cnt = 0;
    while (cur_idx_a != 3'd4 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("pre-reset spike_vec", int'(spike_vec_a), 8'hF0);
    check("pre-reset thr3", int'(dut_a.thr_q[3]), 95);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid rst busy", int'(busy_a), 0);
    check("mid rst cur_idx", int'(cur_idx_a), 0);
    check("mid rst spike_vec", int'(spike_vec_a), 0);
    check("mid rst state3", int'(dut_a.state_q[3]), 0);
    check("mid rst thr3", int'(dut_a.thr_q[3]), 100);
    seen = 1'b0;
    repeat (20) begin
      if (step_done_a || busy_a) seen = 1'b1;
      tick();
    end
    check("mid rst no step_done", int'(seen), 0);
    cur_valid = 1'b0;
    learn_thr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lif_tdm_scheduler.md
Name: lif_tdm_scheduler

Overview:
Time-multiplexes one LIF update datapath across N_NEURONS neurons. Per-neuron membrane state, adaptive threshold and adaptive decay (beta) are held in register arrays. On each timestep the block walks neurons 0..N-1 in order, consuming one input current per neuron over a valid/ready stream. It then publishes a spike vector and a done pulse. It sits between the input encoder (current source) and the spike-consuming layer.

Parameters:
N_NEURONS, 8, neurons served per timestep (2..16)
INIT_THRESHOLD, 100, reset value of every threshold
INIT_BETA, 224, reset value of every beta (224/256 = 0.875)
ADAPT_INC, 295, threshold/beta multiplier on spike (Q8)
ADAPT_DEC, 244, threshold/beta multiplier on no spike (Q8)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
step_start  in  1  pulse: begin one timestep; honoured only in IDLE
learn_thr  in  1  enable threshold adaptation (sampled per update)
learn_beta  in  1  enable beta adaptation (sampled per update)
cur_data  in  8  input current for neuron cur_idx
cur_valid  in  1  cur_data valid
cur_ready  out  1  high only in RUN
cur_idx  out  log2(N)  neuron index expected for the current beat
spike_vec  out  N  per-neuron spike result of the latest timestep
step_done  out  1  one-cycle pulse at end of timestep
busy  out  1  high in RUN and DONE

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE; cur_idx=0; spike_vec=0; step_done=0.
  - All states=0, thresholds=INIT_THRESHOLD, betas=INIT_BETA.
  - Reset mid-RUN aborts the timestep with no partial-update retention beyond the reset values.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: step_start=1 -> RUN, cur_idx=0. step_start outside IDLE is ignored.
  - RUN: cur_ready=1. A beat is accepted on cur_valid&cur_ready, and updates neuron cur_idx in that same edge.
    - Accept at cur_idx=N-1 -> DONE, cur_idx=0.
    - Otherwise cur_idx+1.
    - No accept -> hold (stalls allowed indefinitely).
  - DONE: one cycle; step_done=1 -> IDLE.
- Latency: step_start at edge t; RUN from t+1. With continuous valid, the last accept is at edge t+N and step_done is high during cycle t+N+1.
- Per-neuron update on accept (s=state, th=threshold, b=beta, c=cur_data):
  - spike = (s >= th), evaluated on the pre-update state.
  - spike: s<=0; spike_vec[i]<=1.
    - If learn_thr and th<220: th <= (th*ADAPT_INC)>>8.
    - If learn_beta and b<220: b <= (b*ADAPT_INC)>>8.
  - no spike: s <= sat255(c + ((s*b)>>8)); spike_vec[i]<=0.
    - If learn_thr and th>8: th <= (th*ADAPT_DEC)>>8.
    - If learn_beta and b>128: b <= (b*ADAPT_DEC)>>8.
  - Products are 17-bit unsigned; shifted results are truncated to 8 bits.
  - The sum is 9-bit and saturates to 255 (no wrap).
- spike_vec bits update as each neuron is processed. The full vector is stable from the step_done cycle until the next accept.
- learn_* changes mid-timestep take effect on the next accepted beat.

Decomposition:
- Shared package lif_pkg: STATE_W=8, Q8 shift constant 8, bounds THR_MAX=220, THR_MIN=8, BETA_MAX=220, BETA_MIN=128, FSM state enum.
- Sub-module lif_update_core: purely combinational.
  - Inputs s, th, b, c, learn_thr, learn_beta.
  - Outputs next_s, next_th, next_b, spike.
  - Instantiated once and shared by all neurons.

Test Plan:
1. Reset, learn off, current 50 every beat for all neurons, four timesteps -> states 50, 93, 131; step 4 spike_vec=all ones, states return to 0.
2. learn_thr=1, no spike, current 0 -> th 100->95 after step 1. Separate run, neuron spiking with th=100 -> th 115.
3. INIT_THRESHOLD=250, current 200 -> state 200, then saturates to 255 (200+175). Step 3: spike_vec bit=1.
4. Deassert cur_valid for 5 cycles at cur_idx=3 -> cur_idx holds 3, no state changes, step_done delayed by exactly 5 cycles.
5. step_start pulsed during RUN and DONE -> ignored. cur_valid asserted in IDLE -> cur_ready=0, no update.
6. rst_n low at cur_idx=4 mid-RUN -> next cycle IDLE; all states 0, th=INIT_THRESHOLD, spike_vec=0; step_done never pulses.
